// File: rtl/fpu_cmd_initiator.sv
// CPU-side initiator for the FPU start/done 4-phase handshake.
// Byte-wide register file builds operands/opcode; the FSM runs the handshake and captures the result.
module fpu_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_we,
  input  logic [3:0]  i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_fpu_start,
  output logic [3:0]  o_fpu_op,
  output logic [31:0] o_fpu_a,
  output logic [31:0] o_fpu_b,
  input  logic        i_fpu_done,
  input  logic [31:0] i_fpu_result,
  output logic        o_busy,
  output logic        o_irq
);

  localparam int unsigned CntW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [31:0]     r_a, w_a_d, r_b, w_b_d, r_res, w_res_d;
  logic [3:0]      r_op, w_op_d;
  logic            r_busy, w_busy_d, r_done, w_done_d, r_err, w_err_d, r_irq;
  logic            w_timeout;

  assign w_timeout = (r_cnt == CntMax);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt + 1'b1;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_res_d   = r_res;
    w_op_d    = r_op;
    w_busy_d  = r_busy;
    w_done_d  = r_done;
    w_err_d   = r_err;

    // Status write clears flags first so any same-cycle set below wins.
    if (i_cpu_we && i_cpu_addr == 4'd9) begin
      w_done_d = 1'b0;
      w_err_d  = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (i_cpu_we) begin
          case (i_cpu_addr)
            4'd0: w_a_d[7:0]   = i_cpu_wdata;
            4'd1: w_a_d[15:8]  = i_cpu_wdata;
            4'd2: w_a_d[23:16] = i_cpu_wdata;
            4'd3: w_a_d[31:24] = i_cpu_wdata;
            4'd4: w_b_d[7:0]   = i_cpu_wdata;
            4'd5: w_b_d[15:8]  = i_cpu_wdata;
            4'd6: w_b_d[23:16] = i_cpu_wdata;
            4'd7: w_b_d[31:24] = i_cpu_wdata;
            4'd8: begin
              if (i_cpu_wdata[3:0] == 4'hF) begin
                w_err_d = 1'b1;
              end else begin
                w_op_d    = i_cpu_wdata[3:0];
                w_done_d  = 1'b0;
                w_err_d   = 1'b0;
                w_busy_d  = 1'b1;
                w_state_d = StReq;
              end
            end
            default: ;
          endcase
        end
      end
      StReq: begin
        if (i_fpu_done) begin
          w_res_d   = i_fpu_result;
          w_state_d = StRel;
        end else if (w_timeout) begin
          w_err_d   = 1'b1;
          w_state_d = StRel;
        end
      end
      StRel: begin
        if (!i_fpu_done) begin
          if (!r_err) w_done_d = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end else if (w_timeout) begin
          w_err_d   = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_state_d != r_state) w_cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= 4'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_res   <= w_res_d;
      r_op    <= w_op_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      r_irq   <= w_done_d | w_err_d;
    end
  end

  always_comb begin
    o_cpu_rdata = 8'h00;
    case (i_cpu_addr)
      4'd0:  o_cpu_rdata = r_a[7:0];
      4'd1:  o_cpu_rdata = r_a[15:8];
      4'd2:  o_cpu_rdata = r_a[23:16];
      4'd3:  o_cpu_rdata = r_a[31:24];
      4'd4:  o_cpu_rdata = r_b[7:0];
      4'd5:  o_cpu_rdata = r_b[15:8];
      4'd6:  o_cpu_rdata = r_b[23:16];
      4'd7:  o_cpu_rdata = r_b[31:24];
      4'd8:  o_cpu_rdata = {4'b0, r_op};
      4'd9:  o_cpu_rdata = {5'b0, r_err, r_done, r_busy};
      4'd12: o_cpu_rdata = r_res[7:0];
      4'd13: o_cpu_rdata = r_res[15:8];
      4'd14: o_cpu_rdata = r_res[23:16];
      4'd15: o_cpu_rdata = r_res[31:24];
      default: o_cpu_rdata = 8'h00;
    endcase
  end

  assign o_fpu_start = (r_state == StReq);
  assign o_fpu_op    = r_op;
  assign o_fpu_a     = r_a;
  assign o_fpu_b     = r_b;
  assign o_busy      = r_busy;
  assign o_irq       = r_irq;

endmodule

// File: tb/tb_fpu_cmd_initiator.sv
// Scoreboard bench for fpu_cmd_initiator: stimulus pushes expectations, a negedge monitor
// pops and compares them against the selected DUT output.
module tb_fpu_cmd_initiator;

  localparam int SelRd = 0, SelStart = 1, SelBusy = 2, SelIrq = 3, SelA = 4, SelOp = 5,
                 SelMeas = 6;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        fpu_start;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_done = 1'b0;
  logic [31:0] fpu_result = '0;
  logic        busy, irq;

  exp_t        sb_q[$];
  logic        chk = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          meas = 0;
  int          model_delay = 1;
  logic [31:0] model_res = '0;
  int          model_cnt = 0;

  fpu_cmd_initiator #(.TIMEOUT_CYC(1023)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_rdata  (cpu_rdata),
    .o_fpu_start  (fpu_start),
    .o_fpu_op     (fpu_op),
    .o_fpu_a      (fpu_a),
    .o_fpu_b      (fpu_b),
    .i_fpu_done   (fpu_done),
    .i_fpu_result (fpu_result),
    .o_busy       (busy),
    .o_irq        (irq)
  );

  always #5 clk = ~clk;

  // FPU model: raise done model_delay cycles into start, drop it once start falls.
  always @(posedge clk) begin
    if (fpu_start) begin
      if (!fpu_done) begin
        if (model_cnt + 1 >= model_delay) begin
          fpu_done   <= 1'b1;
          fpu_result <= model_res;
        end else begin
          model_cnt <= model_cnt + 1;
        end
      end
    end else begin
      fpu_done  <= 1'b0;
      model_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      logic [31:0] act;
      exp_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard: got empty queue, required an entry");
      end else begin
        e = sb_q.pop_front();
        case (e.sel)
          SelRd:    act = {24'h0, cpu_rdata};
          SelStart: act = {31'h0, fpu_start};
          SelBusy:  act = {31'h0, busy};
          SelIrq:   act = {31'h0, irq};
          SelA:     act = fpu_a;
          SelOp:    act = {28'h0, fpu_op};
          default:  act = meas;
        endcase
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got %h required %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input int sel, input logic [3:0] addr, input logic [31:0] exp,
                            input string name);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    e.name = name;
    cpu_addr = addr;
    sb_q.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    cpu_we = 1'b1;
    cpu_addr = addr;
    cpu_wdata = data;
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
  endtask

  task automatic wr32(input logic [3:0] base, input logic [31:0] v);
    for (int i = 0; i < 4; i++) wr(base + 4'(i), v[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    expect_val(SelBusy, 4'd0, 32'h0, "busy_clear");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // 1: reset state
    expect_val(SelStart, 4'd0, 32'h0, "rst_start");
    rst = 1'b0;
    for (int a = 0; a < 16; a++) expect_val(SelRd, 4'(a), 32'h0, $sformatf("rst_rd%0d", a));
    expect_val(SelStart, 4'd0, 32'h0, "rst_start_post");
    expect_val(SelIrq, 4'd0, 32'h0, "rst_irq");

    // 2: add 1.0 + 2.0 = 3.0, done one cycle after start
    model_delay = 1;
    model_res = 32'h40400000;
    wr32(4'd0, 32'h3F800000);
    wr32(4'd4, 32'h40000000);
    expect_val(SelRd, 4'd3, 32'h3F, "a_byte3");
    expect_val(SelStart, 4'd0, 32'h0, "pre_start");
    wr(4'd8, 8'h00);
    expect_val(SelStart, 4'd0, 32'h1, "start_t1");
    wait_idle();
    expect_val(SelRd, 4'd12, 32'h00, "add_res0");
    expect_val(SelRd, 4'd13, 32'h00, "add_res1");
    expect_val(SelRd, 4'd14, 32'h40, "add_res2");
    expect_val(SelRd, 4'd15, 32'h40, "add_res3");
    expect_val(SelRd, 4'd9, 32'h02, "add_status");
    expect_val(SelIrq, 4'd0, 32'h1, "add_irq");

    // 3: FPU never answers, REQ times out after 1023 cycles
    model_delay = 5000;
    wr(4'd8, 8'h00);
    meas = 0;
    while (fpu_start === 1'b1 && meas < 3000) begin
      @(posedge clk);
      #1;
      meas++;
    end
    expect_val(SelMeas, 4'd0, 32'd1023, "timeout_cycles");
    wait_idle();
    expect_val(SelRd, 4'd9, 32'h04, "timeout_status");
    expect_val(SelIrq, 4'd0, 32'h1, "timeout_irq");

    // 4: illegal opcode
    wr(4'd9, 8'h00);
    expect_val(SelRd, 4'd9, 32'h00, "clr_status");
    expect_val(SelIrq, 4'd0, 32'h0, "clr_irq");
    wr(4'd8, 8'h0F);
    for (int i = 0; i < 4; i++) expect_val(SelStart, 4'd0, 32'h0, "illegal_nostart");
    expect_val(SelRd, 4'd9, 32'h04, "illegal_status");
    expect_val(SelRd, 4'd8, 32'h00, "illegal_op_kept");

    // 5: writes during busy are ignored; mul 1.0 * 2.0 = 2.0
    model_delay = 20;
    model_res = 32'h40000000;
    wr(4'd8, 8'h01);
    wr(4'd0, 8'hFF);
    wr(4'd8, 8'h03);
    expect_val(SelA, 4'd0, 32'h3F800000, "busy_a_kept");
    expect_val(SelOp, 4'd0, 32'h1, "busy_op_kept");
    wait_idle();
    expect_val(SelRd, 4'd9, 32'h02, "mul_status");
    expect_val(SelRd, 4'd15, 32'h40, "mul_res3");
    expect_val(SelRd, 4'd14, 32'h00, "mul_res2");

    // 6: reset in REQ aborts, then sub 3.0 - 1.0 = 2.0
    model_delay = 50;
    wr(4'd8, 8'h01);
    expect_val(SelStart, 4'd0, 32'h1, "req_start");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_val(SelStart, 4'd0, 32'h0, "abort_start");
    expect_val(SelBusy, 4'd0, 32'h0, "abort_busy");
    repeat (3) @(posedge clk);
    #1;
    model_delay = 1;
    model_res = 32'h40000000;
    wr32(4'd0, 32'h40400000);
    wr32(4'd4, 32'h3F800000);
    wr(4'd8, 8'h02);
    expect_val(SelStart, 4'd0, 32'h1, "sub_start");
    wait_idle();
    expect_val(SelRd, 4'd9, 32'h02, "sub_status");
    expect_val(SelRd, 4'd15, 32'h40, "sub_res3");
    expect_val(SelRd, 4'd12, 32'h00, "sub_res0");
    expect_val(SelRd, 4'd8, 32'h02, "sub_op");
    expect_val(SelIrq, 4'd0, 32'h1, "sub_irq");

    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
